rf_dump: RTL and testbench

RF_DUMP -- requirements
Module: rf_dump

---
 rtl/rf_dump_pkg.sv | 16 +
 rtl/rf_dump.sv | 107 ++++++++++
 tb/tb_rf_dump.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_dump_pkg.sv
// Shared definitions for the register-file dump engine: FSM state encoding
// and default geometry of the scanned register file.
package rf_dump_pkg;

  localparam int NREG_DEFAULT = 32;
  localparam int AW_DEFAULT   = 5;
  localparam int DW_DEFAULT   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rf_dump.sv
// Walks a register file one read port at a time and streams each
// (index, value) pair out over a valid/ready interface.
module rf_dump
  import rf_dump_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  parameter int AW   = AW_DEFAULT,
  parameter int DW   = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          skip_zero,
  output logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] rf_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   out_count
);

  localparam logic [AW-1:0] LAST_IDX  = AW'(NREG - 1);
  localparam logic [AW:0]   MAX_COUNT = (AW + 1)'(NREG);

  state_t        state;
  logic [AW-1:0] idx;
  logic          skip_lat;

  // The read port only sees a live address while fetching, keeping it quiet otherwise.
  assign rf_addr = (state == FETCH) ? idx : '0;
  assign busy    = (state == FETCH) || (state == SEND);

  // NOTE: every register here is updated with <= so all reads in this block see
  // pre-edge values; this also makes a same-edge register-file write invisible to FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      skip_lat  <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      done      <= 1'b0;
      out_count <= '0;
    end else if (abort) begin
      // Abort wins over a simultaneous handshake, so the pending entry is not counted.
      state     <= IDLE;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            idx       <= '0;
            out_count <= '0;
            skip_lat  <= skip_zero;
            state     <= FETCH;
          end
        end

        FETCH: begin
          out_data <= rf_data;
          out_addr <= idx;
          if (skip_lat && (rf_data == '0)) begin
            if (idx == LAST_IDX) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            state     <= SEND;
            out_valid <= 1'b1;
          end
        end

        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_count != MAX_COUNT) out_count <= out_count + 1'b1;
            if (idx == LAST_IDX) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= FETCH;
            end
          end
        end

        DONE: begin
          // A start seen here is dropped; the next scan needs a fresh request in IDLE.
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_dump.sv
// Scoreboard bench for rf_dump: expected entries are queued by the stimulus
// and a negedge monitor pops and compares each accepted entry.
module tb_rf_dump;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        skip_zero;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic [5:0]  out_count;

  logic [31:0] rf [32];
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  entry_t exp_q[$];
  int     checks    = 0;
  int     failures  = 0;
  int     done_cnt  = 0;
  int     done_snap = 0;

  always #5 clk = ~clk;

  rf_dump dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .skip_zero (skip_zero),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .out_count (out_count)
  );

  // Register-file model: combinational read, synchronous write.
  assign rf_data = rf[rf_addr];
  always @(posedge clk) if (rf_we) rf[rf_wa] <= rf_wd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: an entry is accepted at the next posedge when valid && ready,
  // unless abort or reset pre-empts the handshake.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!rst && !abort && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_entry: got addr=%0d data=0x%0h expected none", out_addr, out_data);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        check("entry_addr", 64'(out_addr), 64'(e.addr));
        check("entry_data", 64'(out_data), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    rf_wa = a;
    rf_wd = d;
    rf_we = 1'b1;
    tick();
    rf_we = 1'b0;
  endtask

  task automatic push_entries(input int lo, input int hi, input logic [31:0] r5_val);
    for (int i = lo; i <= hi; i++) begin
      entry_t e;
      e.addr = 5'(i);
      e.data = (i == 5) ? r5_val : 32'(i * 32'h11);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic skip);
    skip_zero = skip;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    skip_zero = 1'b0;
  endtask

  // mode 0: entry with address a presented; mode 1: fetching address a; mode 2: done.
  task automatic wait_until(input int mode, input logic [4:0] a, input string name);
    int n = 0;
    while (!((mode == 0 && out_valid && out_addr == a) ||
             (mode == 1 && busy && !out_valid && rf_addr == a) ||
             (mode == 2 && done)) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout waiting, got none expected event", name);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; skip_zero = 1'b0;
    out_ready = 1'b1; rf_we = 1'b0; rf_wa = '0; rf_wd = '0;
    for (int i = 0; i < 32; i++) rf_write(5'(i), 32'(i * 32'h11));
    check("rst_valid", 64'(out_valid), 0);
    check("rst_busy",  64'(busy),      0);
    check("rst_done",  64'(done),      0);
    check("rst_addr",  64'(out_addr),  0);
    check("rst_data",  64'(out_data),  0);
    check("rst_count", 64'(out_count), 0);
    check("rst_rfaddr", 64'(rf_addr), 0);
    rst = 1'b0;
    tick();

    // Full scan, latency of first entry, and start ignored in the DONE cycle.
    push_entries(0, 31, 32'h55);
    done_snap = done_cnt;
    pulse_start(1'b0);
    check("lat_fetch_busy",  64'(busy),      1);
    check("lat_fetch_valid", 64'(out_valid), 0);
    tick();
    check("lat_send_valid", 64'(out_valid), 1);
    check("lat_send_addr",  64'(out_addr),  0);
    wait_until(2, '0, "scan1_done");
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_one_cycle", 64'(done), 0);
    check("start_in_done_dropped", 64'(busy), 0);
    check("scan1_count", 64'(out_count), 32);
    check("scan1_done_pulses", 64'(done_cnt - done_snap), 1);
    check("scan1_queue_empty", 64'(exp_q.size()), 0);

    // Skip-zero scan: r0 is suppressed.
    push_entries(1, 31, 32'h55);
    done_snap = done_cnt;
    pulse_start(1'b1);
    wait_until(2, '0, "scan2_done");
    tick();
    check("scan2_count", 64'(out_count), 31);
    check("scan2_done_pulses", 64'(done_cnt - done_snap), 1);
    check("scan2_queue_empty", 64'(exp_q.size()), 0);

    // Back-pressure on entry 3.
    push_entries(0, 31, 32'h55);
    pulse_start(1'b0);
    wait_until(0, 5'd3, "stall_entry3");
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", 64'(out_valid), 1);
      check("stall_addr",  64'(out_addr),  3);
      check("stall_data",  64'(out_data),  32'h33);
      tick();
    end
    out_ready = 1'b1;
    wait_until(2, '0, "scan3_done");
    tick();
    check("scan3_count", 64'(out_count), 32);
    check("scan3_queue_empty", 64'(exp_q.size()), 0);

    // Abort during SEND of entry 10 with a ready consumer.
    push_entries(0, 9, 32'h55);
    done_snap = done_cnt;
    pulse_start(1'b0);
    wait_until(0, 5'd10, "abort_entry10");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", 64'(out_valid), 0);
    check("abort_busy",  64'(busy),      0);
    check("abort_count", 64'(out_count), 10);
    repeat (5) tick();
    check("abort_no_done", 64'(done_cnt - done_snap), 0);
    check("abort_queue_empty", 64'(exp_q.size()), 0);

    // Write to r5 in its own FETCH cycle: old value is captured, new one next scan.
    push_entries(0, 31, 32'h55);
    pulse_start(1'b0);
    wait_until(1, 5'd5, "fetch_r5");
    rf_write(5'd5, 32'hDEAD);
    wait_until(2, '0, "scan5a_done");
    tick();
    check("scan5a_queue_empty", 64'(exp_q.size()), 0);
    push_entries(0, 31, 32'hDEAD);
    pulse_start(1'b0);
    wait_until(2, '0, "scan5b_done");
    tick();
    check("scan5b_queue_empty", 64'(exp_q.size()), 0);
    rf_write(5'd5, 32'h55);

    // Reset mid-SEND, then a fresh scan after release.
    push_entries(0, 6, 32'h55);
    done_snap = done_cnt;
    pulse_start(1'b0);
    wait_until(0, 5'd7, "rst_entry7");
    rst = 1'b1;
    #1;
    check("midrst_valid",  64'(out_valid), 0);
    check("midrst_busy",   64'(busy),      0);
    check("midrst_addr",   64'(out_addr),  0);
    check("midrst_data",   64'(out_data),  0);
    check("midrst_count",  64'(out_count), 0);
    check("midrst_rfaddr", 64'(rf_addr),   0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("midrst_no_done", 64'(done_cnt - done_snap), 0);
    check("midrst_queue_empty", 64'(exp_q.size()), 0);
    push_entries(0, 31, 32'h55);
    pulse_start(1'b0);
    wait_until(2, '0, "scan6_done");
    tick();
    check("scan6_count", 64'(out_count), 32);
    check("scan6_queue_empty", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
